ddr3_cmd_responder: RTL and testbench
=====================================

# ddr3_cmd_responder

Synthesizable single-rank DDR3-style memory responder: the device end of the command/data interface that our controller state machine drives. It decodes CS/RAS/CAS/WE/Addr/BA commands, tracks open rows per bank, and accepts write data or returns read data on DQ/LDQS after fixed latencies. It gives the controller a loopback target, on-board or in simulation, with a small internal byte array and protocol-error flags.

## Interface
- CL, 5: read latency in CLK cycles, READ command to DQ driven; legal 2..8
- CWL, 4: write latency, WRITE command to DQ sampled; legal 1..8
- ROW_BITS, 2: row address bits stored (Addr_in[ROW_BITS-1:0])
- COL_BITS, 4: column address bits stored (Addr_in[COL_BITS-1:0])
- CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- CS  in  1  chip select, active low
- RAS  in  1  row strobe, active low
- CAS  in  1  column strobe, active low
- WE  in  1  write enable, active low
- Addr_in  in  15  row/column address; bit 10 is A10
- BA_in  in  3  bank address
- LDM  in  1  write data mask for DQ, active high
- DQ  inout  8  data bus; driven only on read data beat, else high-Z
- LDQS  inout  1  strobe; driven 1 with read data, high-Z otherwise
- row_open  out  8  per-bank open flag
- refresh_count  out  16  REF commands received, wraps at 0xFFFF
- err_no_row  out  1  sticky: READ/WRITE to a closed bank
- err_act_open  out  1  sticky: ACT to an already open bank
- err_bus  out  1  sticky: read beat and write beat due in same cycle

## Operation
- Decode when CS=0, registered on CLK. {RAS,CAS,WE}: 111 NOP, 011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 REF, 000 MRS, 110 ZQCL. CS=1 is deselect (NOP).
- ACT: row_open[BA]=1, open_row[BA]=Addr_in[ROW_BITS-1:0].
- PRE: A10=0 closes bank BA; A10=1 closes all banks.
- READ/WRITE: byte address = {BA, open_row[BA], Addr_in[COL_BITS-1:0]}; memory depth 2^(3+ROW_BITS+COL_BITS) bytes. A10=1 is auto-precharge: bank closes in the command cycle after the address is captured.
- READ/WRITE to a closed bank: command dropped, err_no_row set.
- ACT to open bank: row overwritten, err_act_open set.
- REF: refresh_count++; legal only with all banks closed, otherwise treated as NOP (no flag). MRS/ZQCL: accepted, no effect.
- Pending accesses held in a delay pipeline of depth max(CL,CWL) slots, each {valid, type, address}; back-to-back commands every cycle supported.
- Write beat: at T+CWL sample DQ; write mem unless LDM=1.
- Read beat: at T+CL drive DQ=mem[addr] and LDQS=1 for one cycle. Read sees any write whose beat completed in an earlier cycle.
- Read beat and write beat due same cycle: read wins the bus, write discarded, err_bus set.

## Timing
- Reset: row_open=0, refresh_count=0, all err flags 0, pipeline cleared, DQ/LDQS high-Z from the next edge. Memory contents not cleared.
- RESET mid-burst: pending reads/writes abandoned, no further bus drive.
- Command effect on row_open visible the cycle after the command edge.
- Read data: bus driven exactly in cycle T+CL, for 1 cycle; high-Z at T+CL+1 unless another read is due.
- Error flags assert the cycle after the offending command (err_bus: cycle after collision); cleared only by RESET.

## Configuration
- DDR3_RESP_ERR_EN defined: err_no_row, err_act_open, err_bus are generated as above.
- Undefined: all three tied 0 and error logic removed; illegal commands are still dropped or handled the same way (ACT overwrites, colliding write discarded).

## Test plan
- ACT BA=5 row=1; WRITE col=1 with DQ=0xA5 at T+CWL; READ col=1 -> DQ=0xA5, LDQS=1 exactly at READ+CL, high-Z otherwise.
- WRITE with LDM=1 over 0xA5, DQ=0x3C -> later READ returns 0xA5.
- READ to bank 2 with no ACT -> no DQ drive, err_no_row=1 next cycle; RESET -> flag 0.
- ACT all 8 banks, PRE A10=1 -> row_open=0x00; REF x3 -> refresh_count=3; REF with a bank open -> count unchanged.
- CL=5, CWL=4: READ at T, WRITE at T+1 -> beats collide at T+5, read data driven, err_bus=1, memory unchanged.
- Issue READ, assert RESET at T+2 -> DQ stays high-Z through T+CL, row_open=0.

Source files
------------

// File: rtl/ddr3_cmd_responder.sv
// DDR3-style single-rank device responder: bank/row tracking, fixed-latency read/write beats.
// Define DDR3_RESP_ERR_EN to build the sticky protocol-error flags; otherwise they read 0.
module ddr3_cmd_responder #(
  parameter int CL       = 5,
  parameter int CWL      = 4,
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CS,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WE,
  input  logic [14:0] Addr_in,
  input  logic [2:0]  BA_in,
  input  logic        LDM,
  inout  wire  [7:0]  DQ,
  inout  wire         LDQS,
  output logic [7:0]  row_open,
  output logic [15:0] refresh_count,
  output logic        err_no_row,
  output logic        err_act_open,
  output logic        err_bus
);

  localparam int DEPTH  = (CL > CWL) ? CL : CWL;
  localparam int AW     = 3 + ROW_BITS + COL_BITS;
  localparam int RD_IDX = CL - 1;
  localparam int WR_IDX = CWL - 1;

  // MRS, ZQCL and NOP need no decode: they leave every piece of state alone.
  localparam logic [2:0] CMD_ACT   = 3'b011;
  localparam logic [2:0] CMD_READ  = 3'b101;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_PRE   = 3'b010;
  localparam logic [2:0] CMD_REF   = 3'b001;

  logic [7:0]          rowOpen_q, rowOpen_d;
  logic [ROW_BITS-1:0] openRow_q [8];
  logic [ROW_BITS-1:0] openRow_d [8];
  logic [15:0]         refCount_q, refCount_d;
  logic [DEPTH-1:0]    pipeValid_q, pipeValid_d;
  logic [DEPTH-1:0]    pipeWrite_q, pipeWrite_d;
  logic [AW-1:0]       pipeAddr_q [DEPTH];
  logic [AW-1:0]       pipeAddr_d [DEPTH];
  logic                dqOe_q, dqOe_d;
  logic [7:0]          dqOut_q, dqOut_d;
  logic [7:0]          mem [2**AW];

  logic [2:0]    cmd;
  logic          isAct, isRead, isWrite, isPre, isRef;
  logic          isAccess, bankOpen, accessOk, refOk;
  logic          rdDue, wrDue, wrCommit;
  logic [AW-1:0] cmdAddr;
  logic          unused_addr;

  assign cmd      = {RAS, CAS, WE};
  assign isAct    = !CS && (cmd == CMD_ACT);
  assign isRead   = !CS && (cmd == CMD_READ);
  assign isWrite  = !CS && (cmd == CMD_WRITE);
  assign isPre    = !CS && (cmd == CMD_PRE);
  assign isRef    = !CS && (cmd == CMD_REF);

  assign bankOpen = rowOpen_q[BA_in];
  assign isAccess = isRead || isWrite;
  assign accessOk = isAccess && bankOpen;
  assign refOk    = isRef && (rowOpen_q == 8'h00);
  assign cmdAddr  = {BA_in, openRow_q[BA_in], Addr_in[COL_BITS-1:0]};

  // Only part of the address bus is meaningful for a given geometry.
  assign unused_addr = ^Addr_in;

  always_comb begin
    rowOpen_d = rowOpen_q;
    openRow_d = openRow_q;
    if (isAct) begin
      rowOpen_d[BA_in] = 1'b1;
      openRow_d[BA_in] = Addr_in[ROW_BITS-1:0];
    end
    if (isPre) begin
      if (Addr_in[10]) rowOpen_d = '0;
      else             rowOpen_d[BA_in] = 1'b0;
    end
    // Auto-precharge: the row was already used to form cmdAddr this cycle.
    if (accessOk && Addr_in[10]) rowOpen_d[BA_in] = 1'b0;
  end

  assign refCount_d = refCount_q + 16'(refOk);

  // Slot i holds the access issued i+1 edges ago; beats fire from fixed slots.
  always_comb begin
    pipeValid_d   = {pipeValid_q[DEPTH-2:0], accessOk};
    pipeWrite_d   = {pipeWrite_q[DEPTH-2:0], isWrite};
    pipeAddr_d[0] = cmdAddr;
    for (int i = 1; i < DEPTH; i++) pipeAddr_d[i] = pipeAddr_q[i-1];
  end

  assign rdDue    = pipeValid_q[RD_IDX] && !pipeWrite_q[RD_IDX];
  assign wrDue    = pipeValid_q[WR_IDX] && pipeWrite_q[WR_IDX];
  assign wrCommit = wrDue && !rdDue && !LDM && !RESET;
  assign dqOe_d   = rdDue;
  assign dqOut_d  = mem[pipeAddr_q[RD_IDX]];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rowOpen_q   <= '0;
      refCount_q  <= '0;
      pipeValid_q <= '0;
      dqOe_q      <= 1'b0;
    end else begin
      rowOpen_q   <= rowOpen_d;
      refCount_q  <= refCount_d;
      pipeValid_q <= pipeValid_d;
      dqOe_q      <= dqOe_d;
    end
  end

  // Datapath and storage are qualified by the valid bits, so they carry no reset.
  always_ff @(posedge CLK) begin
    openRow_q   <= openRow_d;
    pipeWrite_q <= pipeWrite_d;
    pipeAddr_q  <= pipeAddr_d;
    dqOut_q     <= dqOut_d;
    if (wrCommit) mem[pipeAddr_q[WR_IDX]] <= DQ;
  end

`ifdef DDR3_RESP_ERR_EN
  logic errNoRow_q, errNoRow_d;
  logic errActOpen_q, errActOpen_d;
  logic errBus_q, errBus_d;

  assign errNoRow_d   = errNoRow_q   || (isAccess && !bankOpen);
  assign errActOpen_d = errActOpen_q || (isAct && bankOpen);
  assign errBus_d     = errBus_q     || (rdDue && wrDue);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      errNoRow_q   <= 1'b0;
      errActOpen_q <= 1'b0;
      errBus_q     <= 1'b0;
    end else begin
      errNoRow_q   <= errNoRow_d;
      errActOpen_q <= errActOpen_d;
      errBus_q     <= errBus_d;
    end
  end

  assign err_no_row   = errNoRow_q;
  assign err_act_open = errActOpen_q;
  assign err_bus      = errBus_q;
`else
  assign err_no_row   = 1'b0;
  assign err_act_open = 1'b0;
  assign err_bus      = 1'b0;
`endif

  assign row_open      = rowOpen_q;
  assign refresh_count = refCount_q;

  assign DQ   = dqOe_q ? dqOut_q : 8'bz;
  assign LDQS = dqOe_q ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Bench for ddr3_cmd_responder: directed scenarios with literal expectations, then random
// command traffic compared every cycle against a model built on beat-time maps.
module tb_ddr3_cmd_responder;

  localparam int CL       = 5;
  localparam int CWL      = 4;
  localparam int ROW_BITS = 2;
  localparam int COL_BITS = 4;
`ifdef DDR3_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [2:0] C_NOP   = 3'b111;
  localparam logic [2:0] C_ACT   = 3'b011;
  localparam logic [2:0] C_READ  = 3'b101;
  localparam logic [2:0] C_WRITE = 3'b100;
  localparam logic [2:0] C_PRE   = 3'b010;
  localparam logic [2:0] C_REF   = 3'b001;
  localparam logic [2:0] C_MRS   = 3'b000;
  localparam logic [2:0] C_ZQCL  = 3'b110;

  logic        CLK = 1'b0;
  logic        RESET, CS, RAS, CAS, WE, LDM;
  logic [14:0] Addr_in;
  logic [2:0]  BA_in;
  wire  [7:0]  DQ;
  wire         LDQS;
  logic [7:0]  row_open;
  logic [15:0] refresh_count;
  logic        err_no_row, err_act_open, err_bus;
  logic [7:0]  tbDq;
  logic        tbDqEn;

  assign DQ = tbDqEn ? tbDq : 8'bz;

  always #5 CLK = ~CLK;

  ddr3_cmd_responder #(.CL(CL), .CWL(CWL), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS)) dut (
    .CLK(CLK), .RESET(RESET), .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE),
    .Addr_in(Addr_in), .BA_in(BA_in), .LDM(LDM), .DQ(DQ), .LDQS(LDQS),
    .row_open(row_open), .refresh_count(refresh_count),
    .err_no_row(err_no_row), .err_act_open(err_act_open), .err_bus(err_bus)
  );

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;

  // Model state: banks, byte store (only addresses ever written are known), beats keyed by edge number.
  bit              mRowOpen [8];
  int              mOpenRow [8];
  byte unsigned    mMem [int];
  int              mRefCount;
  bit              mErrNoRow, mErrAct, mErrBus;
  int              rdAt [int];
  int              wrAt [int];
  int              wrDataAt [int];
  bit              expDrive, expKnown;
  int              expData;
  int              nextWData;
  bit              nextWLdm;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  function automatic bit noneOpen();
    for (int b = 0; b < 8; b++) if (mRowOpen[b]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelEdge();
    int e, addr, col, v;
    bit rd, wr;
    cyc++;
    e = cyc;
    if (RESET) begin
      for (int b = 0; b < 8; b++) mRowOpen[b] = 1'b0;
      mRefCount = 0;
      mErrNoRow = 1'b0;
      mErrAct   = 1'b0;
      mErrBus   = 1'b0;
      rdAt.delete();
      wrAt.delete();
      wrDataAt.delete();
      expDrive = 1'b0;
      return;
    end
    rd = rdAt.exists(e);
    wr = wrAt.exists(e);
    expDrive = rd;
    if (rd) begin
      expKnown = mMem.exists(rdAt[e]);
      if (expKnown) expData = int'(mMem[rdAt[e]]);
      rdAt.delete(e);
    end
    if (wr) begin
      v = wrDataAt[e];
      if (rd) mErrBus = 1'b1;
      else if (!v[8]) mMem[wrAt[e]] = byte'(v[7:0]);
      wrAt.delete(e);
      wrDataAt.delete(e);
    end
    if (!CS) begin
      case ({RAS, CAS, WE})
        C_ACT: begin
          if (mRowOpen[BA_in]) mErrAct = 1'b1;
          mRowOpen[BA_in] = 1'b1;
          mOpenRow[BA_in] = int'(Addr_in) % (1 << ROW_BITS);
        end
        C_PRE: begin
          if (Addr_in[10]) for (int b = 0; b < 8; b++) mRowOpen[b] = 1'b0;
          else mRowOpen[BA_in] = 1'b0;
        end
        C_READ, C_WRITE: begin
          if (!mRowOpen[BA_in]) mErrNoRow = 1'b1;
          else begin
            col  = int'(Addr_in) % (1 << COL_BITS);
            addr = int'(BA_in) * (1 << (ROW_BITS + COL_BITS)) + mOpenRow[BA_in] * (1 << COL_BITS) + col;
            if (WE) rdAt[e + CL] = addr;
            else begin
              wrAt[e + CWL]     = addr;
              wrDataAt[e + CWL] = (int'(nextWLdm) << 8) | (nextWData & 8'hFF);
            end
            if (Addr_in[10]) mRowOpen[BA_in] = 1'b0;
          end
        end
        C_REF: if (noneOpen()) mRefCount = (mRefCount + 1) % 65536;
        default: ;
      endcase
    end
  endtask

  task automatic checkAll();
    int rowVec;
    rowVec = 0;
    for (int b = 0; b < 8; b++) if (mRowOpen[b]) rowVec |= (1 << b);
    checkOutput("row_open", row_open, rowVec);
    checkOutput("refresh_count", refresh_count, mRefCount);
    checkOutput("err_no_row", err_no_row, ERR_EN ? mErrNoRow : 0);
    checkOutput("err_act_open", err_act_open, ERR_EN ? mErrAct : 0);
    checkOutput("err_bus", err_bus, ERR_EN ? mErrBus : 0);
    checkOutput("ldqs_drive", LDQS === 1'b1, expDrive);
    if (expDrive && expKnown) checkOutput("dq_read", DQ, expData);
  endtask

  // One clock: model the edge, release the bus, check, then set idle inputs and any due write data.
  task automatic cycleStep();
    int v;
    @(posedge CLK);
    modelEdge();
    @(negedge CLK);
    tbDqEn = 1'b0;
    LDM    = 1'b0;
    #1;
    checkAll();
    CS = 1'b1; {RAS, CAS, WE} = C_NOP; RESET = 1'b0; BA_in = '0; Addr_in = '0;
    if (wrDataAt.exists(cyc + 1)) begin
      v      = wrDataAt[cyc + 1];
      tbDq   = v[7:0];
      LDM    = v[8];
      tbDqEn = 1'b1;
    end
  endtask

  task automatic applyStimulus(input bit cs, input logic [2:0] rcw, input logic [2:0] ba,
                               input logic [14:0] addr, input bit rst, input int wdata, input bit wldm);
    CS = cs;
    {RAS, CAS, WE} = rcw;
    BA_in = ba;
    Addr_in = addr;
    RESET = rst;
    nextWData = wdata;
    nextWLdm = wldm;
  endtask

  task automatic issue(input logic [2:0] rcw, input logic [2:0] ba, input logic [14:0] addr,
                       input int wdata, input bit wldm);
    applyStimulus(1'b0, rcw, ba, addr, 1'b0, wdata, wldm);
    cycleStep();
  endtask

  task automatic doReset();
    applyStimulus(1'b1, C_NOP, 3'd0, 15'd0, 1'b1, 0, 1'b0);
    cycleStep();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycleStep();
  endtask

  task automatic readExpect(input logic [2:0] ba, input logic [14:0] addr, input int expv, input string tag);
    int t;
    issue(C_READ, ba, addr, 0, 1'b0);
    t = cyc;
    while (cyc < t + CL - 1) cycleStep();
    checkOutput({tag, "_pre_hiz"}, LDQS === 1'b1, 0);
    cycleStep();
    checkOutput({tag, "_ldqs"}, LDQS === 1'b1, 1);
    checkOutput({tag, "_dq"}, DQ, expv);
    cycleStep();
    checkOutput({tag, "_post_hiz"}, LDQS === 1'b1, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int r;
    logic [2:0]  rcw, ba;
    logic [14:0] a;
    bit cs, rst;

    tbDqEn = 1'b0; tbDq = '0; LDM = 1'b0;
    nextWData = 0; nextWLdm = 1'b0;
    applyStimulus(1'b1, C_NOP, 3'd0, 15'd0, 1'b1, 0, 1'b0);
    cycleStep();
    doReset();
    checkOutput("reset_row_open", row_open, 0);
    checkOutput("reset_refresh", refresh_count, 0);
    checkOutput("reset_ldqs_hiz", LDQS === 1'b1, 0);

    // Basic write then read-back through bank 5, row 1, column 1.
    issue(C_ACT, 3'd5, 15'd1, 0, 1'b0);
    checkOutput("act5_row_open", row_open, 8'h20);
    issue(C_WRITE, 3'd5, 15'd1, 8'hA5, 1'b0);
    readExpect(3'd5, 15'd1, 8'hA5, "rd_a5");

    // Masked write must leave the stored byte alone.
    issue(C_WRITE, 3'd5, 15'd1, 8'h3C, 1'b1);
    idle(CWL + 1);
    readExpect(3'd5, 15'd1, 8'hA5, "rd_masked");

    // Read to a bank that was never activated.
    issue(C_READ, 3'd2, 15'd0, 0, 1'b0);
    checkOutput("no_row_flag", err_no_row, ERR_EN);
    for (int i = 0; i < CL + 1; i++) begin
      cycleStep();
      checkOutput("no_row_hiz", LDQS === 1'b1, 0);
    end
    doReset();
    checkOutput("no_row_cleared", err_no_row, 0);

    // Bank bookkeeping and refresh legality.
    for (int b = 0; b < 8; b++) issue(C_ACT, 3'(b), 15'(b % 4), 0, 1'b0);
    checkOutput("all_open", row_open, 8'hFF);
    issue(C_ACT, 3'd0, 15'd2, 0, 1'b0);
    checkOutput("act_open_flag", err_act_open, ERR_EN);
    issue(C_PRE, 3'd0, 15'h0400, 0, 1'b0);
    checkOutput("pre_all", row_open, 8'h00);
    for (int i = 0; i < 3; i++) issue(C_REF, 3'd0, 15'd0, 0, 1'b0);
    checkOutput("ref_x3", refresh_count, 3);
    issue(C_ACT, 3'd0, 15'd0, 0, 1'b0);
    issue(C_REF, 3'd0, 15'd0, 0, 1'b0);
    checkOutput("ref_blocked", refresh_count, 3);
    issue(C_PRE, 3'd0, 15'd0, 0, 1'b0);
    checkOutput("pre_one", row_open, 8'h00);

    // Read at T and write at T+1 land on the same edge: read wins.
    issue(C_ACT, 3'd1, 15'd0, 0, 1'b0);
    issue(C_WRITE, 3'd1, 15'd2, 8'h11, 1'b0);
    idle(CWL + 1);
    issue(C_READ, 3'd1, 15'd2, 0, 1'b0);
    t = cyc;
    issue(C_WRITE, 3'd1, 15'd2, 8'h77, 1'b0);
    while (cyc < t + CL) cycleStep();
    checkOutput("collide_ldqs", LDQS === 1'b1, 1);
    checkOutput("collide_dq", DQ, 8'h11);
    checkOutput("collide_err_bus", err_bus, ERR_EN);
    idle(2);
    readExpect(3'd1, 15'd2, 8'h11, "after_collide");

    // Reset in the middle of a pending read.
    issue(C_ACT, 3'd3, 15'd2, 0, 1'b0);
    issue(C_READ, 3'd3, 15'd0, 0, 1'b0);
    t = cyc;
    idle(1);
    doReset();
    checkOutput("rst_burst_row_open", row_open, 0);
    while (cyc < t + CL + 1) begin
      cycleStep();
      checkOutput("rst_burst_hiz", LDQS === 1'b1, 0);
    end

    // Random traffic over a small address window so reads often hit known bytes.
    for (int n = 0; n < 3000; n++) begin
      r   = $urandom_range(0, 99);
      ba  = 3'($urandom_range(0, 7));
      a   = 15'($urandom);
      a[10] = ($urandom_range(0, 7) == 0);
      cs  = 1'b0;
      rst = 1'b0;
      if (r < 20) begin
        rcw = C_ACT;
        a[1:0] = 2'($urandom_range(0, 1));
      end else if (r < 45) begin
        rcw = C_READ;
        a[3:0] = 4'($urandom_range(0, 1));
      end else if (r < 70) begin
        rcw = C_WRITE;
        a[3:0] = 4'($urandom_range(0, 1));
      end else if (r < 80) rcw = C_PRE;
      else if (r < 86) rcw = C_REF;
      else if (r < 89) rcw = C_MRS;
      else if (r < 92) rcw = C_ZQCL;
      else if (r < 96) begin
        rcw = 3'($urandom_range(0, 7));
        cs  = 1'b1;
      end else if (r < 99) rcw = C_NOP;
      else begin
        rcw = C_NOP;
        rst = 1'b1;
      end
      // Keep a read beat from sitting directly before a write beat (bus turnaround).
      if (!cs && rcw == C_READ && wrAt.exists(cyc + 1 + CL + 1)) rcw = C_NOP;
      if (!cs && rcw == C_WRITE && rdAt.exists(cyc + 1 + CWL - 1)) rcw = C_NOP;
      applyStimulus(cs, rcw, ba, a, rst, int'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0));
      cycleStep();
    end
    idle(CL + 2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
